// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per cycle on a valid/ready stream.
// Define AES_KEY_EXPAND_STORE_EN to keep all 11 round keys readable via rd_idx_i/rd_key_o.

module sub_bytes (
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);
    // Forward AES S-box, entry 0 in the lowest-numbered byte of an ascending vector.
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    assign word_o = {sbox(word_i[31:24]), sbox(word_i[23:16]),
                     sbox(word_i[15:8]),  sbox(word_i[7:0])};
endmodule

module aes_key_expand #(
    parameter int NUM_ROUNDS = 10,
    parameter int RIDX_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [127:0]      key_i,
    output logic              ready_o,
    output logic              rk_valid_o,
    input  logic              rk_ready_i,
    output logic [127:0]      round_key_o,
    output logic [RIDX_W-1:0] round_idx_o,
    output logic              done_o,
    input  logic [RIDX_W-1:0] rd_idx_i,
    output logic [127:0]      rd_key_o
);
    // state | meaning: IDLE accepts start; EMIT presents round key; DONE one-cycle done pulse
    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_e;

    state_e            state_q, state_d;
    logic [127:0]      key_q, key_d;
    logic [RIDX_W-1:0] ridx_q, ridx_d;
    logic [7:0]        rcon_q, rcon_d;

    logic              xfer;
    logic              last;
    logic [31:0]       w0, w1, w2, w3;
    logic [31:0]       rot, sub, t;
    logic [31:0]       n0, n1, n2, n3;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    assign xfer = (state_q == EMIT) && rk_ready_i;
    assign last = (ridx_q == RIDX_W'(NUM_ROUNDS));

    assign {w0, w1, w2, w3} = key_q;
    assign rot = {w3[23:0], w3[31:24]};

    sub_bytes u_sub_bytes (
        .word_i (rot),
        .word_o (sub)
    );

    assign t  = sub ^ {rcon_q, 24'h000000};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = EMIT;
            EMIT:    if (xfer && last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_o    = 1'b0;
        rk_valid_o = 1'b0;
        done_o     = 1'b0;
        case (state_q)
            IDLE:    ready_o    = 1'b1;
            EMIT:    rk_valid_o = 1'b1;
            DONE:    done_o     = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        key_d  = key_q;
        ridx_d = ridx_q;
        rcon_d = rcon_q;
        if (state_q == IDLE && start_i) begin
            key_d  = key_i;
            ridx_d = '0;
            rcon_d = 8'h01;
        end else if (xfer && !last) begin
            key_d  = {n0, n1, n2, n3};
            ridx_d = ridx_q + RIDX_W'(1);
            rcon_d = xtime(rcon_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q  <= '0;
            ridx_q <= '0;
            rcon_q <= 8'h01;
        end else begin
            key_q  <= key_d;
            ridx_q <= ridx_d;
            rcon_q <= rcon_d;
        end
    end

    assign round_key_o = key_q;
    assign round_idx_o = ridx_q;

`ifdef AES_KEY_EXPAND_STORE_EN
    logic [127:0] store_q [NUM_ROUNDS+1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) store_q[i] <= '0;
        end else if (state_q == IDLE && start_i) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) store_q[i] <= '0;
        end else if (xfer) begin
            store_q[ridx_q] <= key_q;
        end
    end

    assign rd_key_o = (rd_idx_i <= RIDX_W'(NUM_ROUNDS)) ? store_q[rd_idx_i] : '0;
`else
    logic rd_idx_unused;
    assign rd_idx_unused = ^rd_idx_i;
    assign rd_key_o      = '0;
`endif

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Iterative AES-128 key schedule generating the 11 round keys (round 0..10) from a 128-bit cipher key.
- Sits beside the round datapath and feeds AddRoundKey.
- Instantiates the existing 4-byte S-box substitution module `sub_bytes` for SubWord(RotWord(w3)).
- Produces one round key per cycle on a valid/ready stream.

Parameters:
- NUM_ROUNDS, 10, number of rounds after round 0; only 10 is supported (AES-128).
- RIDX_W, 4, width of the round index output.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- start_i  input  1  request a new expansion; accepted only when ready_o=1
- key_i  input  128  cipher key; key_i[127:120] is byte 0; sampled on accepted start
- ready_o  output  1  block idle, can accept start
- rk_valid_o  output  1  round_key_o holds a valid round key
- rk_ready_i  input  1  consumer accepts round key this cycle
- round_key_o  output  128  current round key, same byte order as key_i
- round_idx_o  output  RIDX_W  index of round_key_o, 0..NUM_ROUNDS
- done_o  output  1  one-cycle pulse after round NUM_ROUNDS key is accepted
- rd_idx_i  input  RIDX_W  stored round key select (optional feature)
- rd_key_o  output  128  stored round key (optional feature)

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - ready_o=1, rk_valid_o=0, done_o=0.
  - round_key_o=0, round_idx_o=0, rcon register=8'h01.
  - Optional store is cleared to 0.
- FSM IDLE:
  - ready_o=1.
  - On start_i=1: load key register with key_i, round_idx=0, rcon=8'h01, go to EMIT.
  - rk_valid_o rises in the cycle after start.
- FSM EMIT:
  - ready_o=0, rk_valid_o=1.
  - round_key_o and round_idx_o are driven from registers.
- Handshake:
  - Transfer occurs when rk_valid_o & rk_ready_i.
  - While valid & !ready, round_key_o and round_idx_o hold stable.
- On transfer with round_idx < NUM_ROUNDS:
  - Next key is computed combinationally from the current key (words w0..w3, w0 = bits 127:96):
    - t = sub_bytes(RotWord(w3)) ^ {rcon,24'h0}, where RotWord takes bytes (b1,b2,b3,b0)
    - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2
  - The result is registered; round_idx increments.
  - rcon <= xtime(rcon): shift left 1, XOR 8'h1b if bit7 was set (8'h80 -> 8'h1b).
  - rk_valid_o stays 1, giving full throughput: 11 keys in 11 cycles with ready tied high.
- On transfer with round_idx == NUM_ROUNDS: go to DONE.
- FSM DONE:
  - One cycle: done_o=1, rk_valid_o=0, ready_o=0.
  - Then IDLE.
- Simultaneous events: start_i while not in IDLE is ignored (no effect, no queueing).
- Reset mid-expansion: immediate abort to IDLE; no done_o pulse.
- Latency: start accepted at cycle 0 -> round 0 key valid at cycle 1 -> round 10 key valid at cycle 11 (ready=1) -> done_o at cycle 12 -> ready_o=1 at cycle 13.

Optional Feature:
- Macro: AES_KEY_EXPAND_STORE_EN.
- Defined:
  - An 11 x 128 register file captures each round key at its transfer, indexed by round_idx.
  - rd_key_o = store[rd_idx_i] combinationally; rd_idx_i > NUM_ROUNDS returns 0.
  - Contents persist until the next accepted start (cleared on start) or reset.
  - Lets a decryptor read keys in reverse order.
- Not defined: no storage; rd_key_o tied to 0; rd_idx_i unused.

Test Plan:
- FIPS-197 vector, key_i=2b7e151628aed2a6abf7158809cf4f3c, rk_ready_i=1:
  - Round 0 = key.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at cycle 11.
  - done_o pulses at cycle 12.
- Back-pressure with the same key, rk_ready_i toggled randomly (including 5-cycle stalls at round 3): round_key_o/round_idx_o stable during stalls; same 11 keys in order; no key duplicated or skipped.
- Rcon wrap, key_i=0: round 9 key uses rcon 8'h1b; round 10 uses 8'h36. Round 10 key = b4ef5bcb3e92e21123e951cf6f8f188e.
- start_i asserted in EMIT with a different key at round 4: ignored, key sequence unchanged, ready_o stays 0.
- rst asserted at round 6: outputs return to reset values asynchronously, no done_o. A new start after release yields round 0 = new key.
- With AES_KEY_EXPAND_STORE_EN, after the FIPS-197 run:
  - rd_idx_i=1 -> a0fafe17...7605.
  - rd_idx_i=10 -> d014f9a8...0ca6.
  - rd_idx_i=12 -> 0.
  - Without the macro, rd_key_o=0 for all indices.
